// File: rtl/keccak_stream_driver.sv
// Initiator-side driver for a Keccak core: streams host message bytes into the core sink,
// controls start/stop, and forwards the squeezed digest truncated to the requested length.
module keccak_stream_driver #(
    parameter int DWIDTH           = 64,
    parameter int OUT_DWIDTH       = 256,
    parameter int MODE_W           = 2,
    parameter int LEN_W            = 32,
    parameter int STOP_HOLD_CYCLES = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [MODE_W-1:0]       cmd_mode_i,
    input  logic [LEN_W-1:0]        cmd_msg_len_i,
    input  logic [LEN_W-1:0]        cmd_out_len_i,
    input  logic                    abort_i,
    input  logic [DWIDTH-1:0]       msg_data_i,
    input  logic                    msg_valid_i,
    output logic                    msg_ready_o,
    output logic                    start_o,
    output logic [MODE_W-1:0]       mode_o,
    output logic                    stop_o,
    output logic [DWIDTH-1:0]       m_t_data_o,
    output logic [DWIDTH/8-1:0]     m_t_keep_o,
    output logic                    m_t_valid_o,
    output logic                    m_t_last_o,
    input  logic                    m_t_ready_i,
    input  logic [OUT_DWIDTH-1:0]   s_t_data_i,
    input  logic [OUT_DWIDTH/8-1:0] s_t_keep_i,
    input  logic                    s_t_valid_i,
    input  logic                    s_t_last_i,
    output logic                    s_t_ready_o,
    output logic [OUT_DWIDTH-1:0]   dig_data_o,
    output logic [OUT_DWIDTH/8-1:0] dig_keep_o,
    output logic                    dig_valid_o,
    output logic                    dig_last_o,
    input  logic                    dig_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int KEEP_W     = DWIDTH / 8;
    localparam int OUT_KEEP_W = OUT_DWIDTH / 8;
    localparam int CNT_W      = $clog2(STOP_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEND  = 3'd2,
        ST_RECV  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [MODE_W-1:0]       mode_r;
    logic [LEN_W-1:0]        msg_rem_r, out_rem_r;
    logic                    out_lim_r, fin_r, abort_r, done_r;
    logic [CNT_W-1:0]        hold_r;
    logic [OUT_DWIDTH-1:0]   dig_data_r;
    logic [OUT_KEEP_W-1:0]   dig_keep_r;
    logic                    dig_valid_r, dig_last_r;

    logic [KEEP_W-1:0]       msg_keep_s;
    logic [OUT_KEEP_W-1:0]   out_mask_s, kept_keep_s;
    logic [LEN_W-1:0]        kept_n_s;
    logic                    msg_empty_s, msg_tail_s, msg_acc_s, s_ready_s, s_acc_s, reach0_s, abort_s;

    function automatic logic [LEN_W-1:0] popcount(input logic [OUT_KEEP_W-1:0] v);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_KEEP_W; i++) n = n + LEN_W'(v[i]);
        return n;
    endfunction

    // Byte-enable masks for the remaining message and remaining output byte counts
    always_comb begin
        for (int i = 0; i < KEEP_W; i++) msg_keep_s[i] = (msg_rem_r > LEN_W'(i));
        for (int i = 0; i < OUT_KEEP_W; i++) out_mask_s[i] = ~out_lim_r | (out_rem_r > LEN_W'(i));
    end

    assign abort_s     = abort_i & (state_r != ST_IDLE);
    assign msg_empty_s = (msg_rem_r == '0);
    assign msg_tail_s  = (msg_rem_r <= LEN_W'(KEEP_W));
    assign msg_acc_s   = (state_r == ST_SEND) & ~abort_i & ~msg_empty_s & msg_valid_i & m_t_ready_i;
    assign s_ready_s   = (state_r == ST_RECV) & ~fin_r & (~dig_valid_r | dig_ready_i);
    assign s_acc_s     = s_t_valid_i & s_ready_s;
    assign kept_keep_s = s_t_keep_i & out_mask_s;
    assign kept_n_s    = popcount(kept_keep_s);
    assign reach0_s    = out_lim_r & (out_rem_r == kept_n_s);

    // Next-state decode and the combinational sink-side beat generation
    always_comb begin
        state_s     = state_r;
        m_t_valid_o = 1'b0;
        m_t_data_o  = '0;
        m_t_keep_o  = '0;
        m_t_last_o  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) state_s = ST_START;
                else             state_s = ST_IDLE;
            end
            ST_START: begin
                if (abort_i) state_s = ST_STOP;
                else         state_s = ST_SEND;
            end
            ST_SEND: begin
                if (abort_i) begin
                    state_s = ST_STOP;
                end else if (msg_empty_s) begin
                    // Zero-length message still needs one terminating beat
                    m_t_valid_o = 1'b1;
                    m_t_last_o  = 1'b1;
                    if (m_t_ready_i) state_s = ST_RECV;
                    else             state_s = ST_SEND;
                end else begin
                    m_t_valid_o = msg_valid_i;
                    m_t_data_o  = msg_data_i;
                    m_t_keep_o  = msg_keep_s;
                    m_t_last_o  = msg_tail_s & msg_valid_i;
                    if (msg_acc_s && msg_tail_s) state_s = ST_RECV;
                    else                         state_s = ST_SEND;
                end
            end
            ST_RECV: begin
                if (abort_i)                                 state_s = ST_STOP;
                else if (s_acc_s && s_t_last_i)              state_s = ST_RECV;
                else if (s_acc_s && reach0_s)                state_s = ST_STOP;
                else if (fin_r && dig_valid_r && dig_ready_i) state_s = ST_IDLE;
                else                                         state_s = ST_RECV;
            end
            ST_STOP: begin
                if (hold_r >= CNT_W'(STOP_HOLD_CYCLES - 1) && !dig_valid_r) state_s = ST_IDLE;
                else                                                        state_s = ST_STOP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Command latch and byte-count bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= '0;
            msg_rem_r <= '0;
            out_rem_r <= '0;
            out_lim_r <= 1'b0;
            abort_r   <= 1'b0;
            fin_r     <= 1'b0;
            hold_r    <= '0;
            done_r    <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && cmd_valid_i) begin
                mode_r    <= cmd_mode_i;
                msg_rem_r <= cmd_msg_len_i;
                out_rem_r <= cmd_out_len_i;
                out_lim_r <= (cmd_out_len_i != '0);
                abort_r   <= 1'b0;
            end else begin
                if (msg_acc_s) msg_rem_r <= msg_tail_s ? '0 : msg_rem_r - LEN_W'(KEEP_W);
                if (s_acc_s && out_lim_r) out_rem_r <= out_rem_r - kept_n_s;
                if (abort_s) abort_r <= 1'b1;
            end
            fin_r <= (state_r == ST_RECV) & (fin_r | (s_acc_s & s_t_last_i));
            if (state_r != ST_STOP) hold_r <= '0;
            else if (hold_r != CNT_W'(STOP_HOLD_CYCLES)) hold_r <= hold_r + CNT_W'(1);
            else hold_r <= hold_r;
            done_r <= (state_r != ST_IDLE) & (state_s == ST_IDLE) & ~abort_r & ~abort_i;
        end
    end

    // Digest output register; an abort discards any beat still pending downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_data_r  <= '0;
            dig_keep_r  <= '0;
            dig_valid_r <= 1'b0;
            dig_last_r  <= 1'b0;
        end else if (abort_s) begin
            dig_data_r  <= '0;
            dig_keep_r  <= '0;
            dig_valid_r <= 1'b0;
            dig_last_r  <= 1'b0;
        end else if (s_acc_s) begin
            dig_data_r  <= s_t_data_i;
            dig_keep_r  <= kept_keep_s;
            dig_valid_r <= 1'b1;
            dig_last_r  <= s_t_last_i | reach0_s;
        end else if (dig_ready_i) begin
            dig_valid_r <= 1'b0;
        end else begin
            dig_valid_r <= dig_valid_r;
        end
    end

    assign cmd_ready_o = (state_r == ST_IDLE);
    assign busy_o      = (state_r != ST_IDLE);
    assign start_o     = (state_r == ST_START);
    assign stop_o      = (state_r == ST_STOP);
    assign mode_o      = mode_r;
    assign msg_ready_o = msg_acc_s;
    assign s_t_ready_o = s_ready_s;
    assign dig_data_o  = dig_data_r;
    assign dig_keep_o  = dig_keep_r;
    assign dig_valid_o = dig_valid_r;
    assign dig_last_o  = dig_last_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_keccak_stream_driver.sv
// Directed bench for keccak_stream_driver; the bench plays both host and Keccak core.
module tb_keccak_stream_driver;
    localparam logic [1:0]   MODE_SHA3_256 = 2'd1;
    localparam logic [1:0]   MODE_SHAKE128 = 2'd2;
    localparam logic [31:0]  ONES    = 32'hFFFF_FFFF;
    localparam logic [255:0] D_ABC   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
    localparam logic [255:0] D_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;

    logic         clk, rst_n;
    logic         cmd_valid_i, cmd_ready_o;
    logic [1:0]   cmd_mode_i;
    logic [31:0]  cmd_msg_len_i, cmd_out_len_i;
    logic         abort_i;
    logic [63:0]  msg_data_i;
    logic         msg_valid_i, msg_ready_o;
    logic         start_o, stop_o;
    logic [1:0]   mode_o;
    logic [63:0]  m_t_data_o;
    logic [7:0]   m_t_keep_o;
    logic         m_t_valid_o, m_t_last_o, m_t_ready_i;
    logic [255:0] s_t_data_i;
    logic [31:0]  s_t_keep_i;
    logic         s_t_valid_i, s_t_last_i, s_t_ready_o;
    logic [255:0] dig_data_o;
    logic [31:0]  dig_keep_o;
    logic         dig_valid_o, dig_last_o, dig_ready_i, busy_o, done_o;

    int checks = 0;
    int failures = 0;
    int stop_cycles = 0;
    int done_cnt = 0;
    int dig_acc = 0;

    keccak_stream_driver dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_mode_i(cmd_mode_i),
        .cmd_msg_len_i(cmd_msg_len_i), .cmd_out_len_i(cmd_out_len_i), .abort_i(abort_i),
        .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .start_o(start_o), .mode_o(mode_o), .stop_o(stop_o),
        .m_t_data_o(m_t_data_o), .m_t_keep_o(m_t_keep_o), .m_t_valid_o(m_t_valid_o),
        .m_t_last_o(m_t_last_o), .m_t_ready_i(m_t_ready_i),
        .s_t_data_i(s_t_data_i), .s_t_keep_i(s_t_keep_i), .s_t_valid_i(s_t_valid_i),
        .s_t_last_i(s_t_last_i), .s_t_ready_o(s_t_ready_o),
        .dig_data_o(dig_data_o), .dig_keep_o(dig_keep_o), .dig_valid_o(dig_valid_o),
        .dig_last_o(dig_last_o), .dig_ready_i(dig_ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors sampled mid-cycle
    always @(negedge clk) begin
        if (stop_o) stop_cycles++;
        if (done_o) done_cnt++;
        if (dig_valid_o && dig_ready_i) dig_acc++;
    end

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] mode, input logic [31:0] ml, input logic [31:0] ol);
        cmd_valid_i = 1'b1; cmd_mode_i = mode; cmd_msg_len_i = ml; cmd_out_len_i = ol;
        #1 check_eq("cmd_ready", cmd_ready_o, 1);
        step();
        cmd_valid_i = 1'b0;
        check_eq("start_hi", start_o, 1);
        check_eq("mode", mode_o, mode);
        check_eq("busy", busy_o, 1);
        step();
        check_eq("start_pulse", start_o, 0);
    endtask

    task automatic sink_beat(input logic [63:0] d, input logic [7:0] ek, input logic el, input int gap);
        for (int g = 0; g < gap; g++) begin
            msg_valid_i = 1'b0; m_t_ready_i = 1'b1;
            #1 check_eq("gap_valid", m_t_valid_o, 0);
            check_eq("gap_last", m_t_last_o, 0);
            step();
        end
        msg_valid_i = 1'b1; msg_data_i = d; m_t_ready_i = 1'b1;
        #1 check_eq("sink_valid", m_t_valid_o, 1);
        check_eq("sink_keep", m_t_keep_o, ek);
        check_eq("sink_last", m_t_last_o, el);
        check_eq("sink_data", m_t_data_o, d);
        check_eq("msg_ready", msg_ready_o, 1);
        step();
        msg_valid_i = 1'b0;
    endtask

    task automatic core_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                             input logic [31:0] ek, input logic el);
        s_t_valid_i = 1'b1; s_t_data_i = d; s_t_keep_i = k; s_t_last_i = l; dig_ready_i = 1'b1;
        #1 check_eq("s_ready", s_t_ready_o, 1);
        step();
        s_t_valid_i = 1'b0; s_t_last_i = 1'b0;
        check_eq("dig_valid", dig_valid_o, 1);
        check_eq("dig_data", dig_data_o, d);
        check_eq("dig_keep", dig_keep_o, ek);
        check_eq("dig_last", dig_last_o, el);
    endtask

    task automatic expect_done(input string tag);
        step();
        check_eq({tag, "_done"}, done_o, 1);
        check_eq({tag, "_idle"}, cmd_ready_o, 1);
        step();
        check_eq({tag, "_done_clr"}, done_o, 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && !cmd_ready_o; i++) step();
        check_eq({tag, "_idle_timeout"}, cmd_ready_o, 1);
    endtask

    task automatic run_abc(input string tag);
        int s0;
        s0 = stop_cycles;
        issue_cmd(MODE_SHA3_256, 32'd3, 32'd32);
        sink_beat(64'h0000_0000_0063_6261, 8'h07, 1'b1, 0);
        check_eq({tag, "_recv_tvalid"}, m_t_valid_o, 0);
        core_beat(D_ABC, ONES, 1'b1, ONES, 1'b1);
        expect_done(tag);
        check_eq({tag, "_no_stop"}, stop_cycles - s0, 0);
    endtask

    initial begin
        int s0, d0, a0;
        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_mode_i = 2'd0; cmd_msg_len_i = 32'd0;
        cmd_out_len_i = 32'd0; abort_i = 1'b0; msg_data_i = 64'd0; msg_valid_i = 1'b0;
        m_t_ready_i = 1'b0; s_t_data_i = 256'd0; s_t_keep_i = 32'd0; s_t_valid_i = 1'b0;
        s_t_last_i = 1'b0; dig_ready_i = 1'b1;
        repeat (3) step();
        check_eq("rst_cmd_ready", cmd_ready_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_start", start_o, 0);
        check_eq("rst_stop", stop_o, 0);
        check_eq("rst_tvalid", m_t_valid_o, 0);
        check_eq("rst_dig_valid", dig_valid_o, 0);
        check_eq("rst_dig_data", dig_data_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_s_ready", s_t_ready_o, 0);
        rst_n = 1'b1;
        step();

        // 1: SHA3-256 "abc"
        run_abc("t1");

        // 2: empty message
        issue_cmd(MODE_SHA3_256, 32'd0, 32'd32);
        msg_valid_i = 1'b1; m_t_ready_i = 1'b1;
        #1 check_eq("t2_valid", m_t_valid_o, 1);
        check_eq("t2_keep", m_t_keep_o, 8'h00);
        check_eq("t2_last", m_t_last_o, 1);
        check_eq("t2_data", m_t_data_o, 0);
        check_eq("t2_no_msg_ready", msg_ready_o, 0);
        step();
        msg_valid_i = 1'b0;
        core_beat(D_EMPTY, ONES, 1'b1, ONES, 1'b1);
        expect_done("t2");

        // 3: 17 bytes -> three beats, with host gaps and one core stall
        issue_cmd(MODE_SHA3_256, 32'd17, 32'd32);
        sink_beat(64'h0706_0504_0302_0100, 8'hFF, 1'b0, 0);
        msg_valid_i = 1'b1; msg_data_i = 64'h0F0E_0D0C_0B0A_0908; m_t_ready_i = 1'b0;
        #1 check_eq("t3_stall_valid", m_t_valid_o, 1);
        check_eq("t3_stall_ready", msg_ready_o, 0);
        step();
        sink_beat(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b0, 2);
        sink_beat(64'h0000_0000_0000_0010, 8'h01, 1'b1, 3);
        core_beat(D_ABC, ONES, 1'b1, ONES, 1'b1);
        expect_done("t3");

        // 4: SHAKE128, 200 output bytes -> 7 beats then stop hold
        s0 = stop_cycles;
        issue_cmd(MODE_SHAKE128, 32'd0, 32'd200);
        m_t_ready_i = 1'b1;
        step();
        for (int b = 0; b < 7; b++) begin
            if (b < 6) core_beat(256'(b + 1), ONES, 1'b0, ONES, 1'b0);
            else       core_beat(256'(b + 1), ONES, 1'b0, 32'h0000_00FF, 1'b1);
        end
        check_eq("t4_stop", stop_o, 1);
        check_eq("t4_s_ready_stop", s_t_ready_o, 0);
        wait_idle("t4");
        check_eq("t4_done", done_o, 1);
        check_eq("t4_stop_cycles", stop_cycles - s0, 128);

        // 5: downstream backpressure, out_len 0 ends on core t_last
        step();
        a0 = dig_acc;
        issue_cmd(MODE_SHAKE128, 32'd0, 32'd0);
        step();
        dig_ready_i = 1'b0; s_t_valid_i = 1'b1; s_t_data_i = 256'hA; s_t_keep_i = ONES;
        #1 check_eq("t5_s_ready0", s_t_ready_o, 1);
        step();
        s_t_data_i = 256'hB;
        for (int i = 0; i < 10; i++) begin
            check_eq("t5_hold_data", dig_data_o, 256'hA);
            check_eq("t5_hold_valid", dig_valid_o, 1);
            check_eq("t5_hold_sready", s_t_ready_o, 0);
            step();
        end
        dig_ready_i = 1'b1;
        #1 check_eq("t5_s_ready1", s_t_ready_o, 1);
        step();
        s_t_valid_i = 1'b0;
        check_eq("t5_beat_b", dig_data_o, 256'hB);
        check_eq("t5_last_b", dig_last_o, 0);
        core_beat(256'hC, ONES, 1'b1, ONES, 1'b1);
        expect_done("t5");
        check_eq("t5_dig_count", dig_acc - a0, 3);

        // 6a: reset during SEND, then a clean command
        issue_cmd(MODE_SHA3_256, 32'd17, 32'd32);
        msg_valid_i = 1'b1; m_t_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_eq("t6_rst_cmd_ready", cmd_ready_o, 1);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_tvalid", m_t_valid_o, 0);
        check_eq("t6_rst_msg_ready", msg_ready_o, 0);
        msg_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_abc("t6a");

        // 6b: abort during RECV with a digest beat pending downstream
        d0 = done_cnt;
        issue_cmd(MODE_SHAKE128, 32'd3, 32'd96);
        sink_beat(64'h0000_0000_0063_6261, 8'h07, 1'b1, 0);
        core_beat(256'h1, ONES, 1'b0, ONES, 1'b0);
        step();
        dig_ready_i = 1'b0; s_t_valid_i = 1'b1; s_t_data_i = 256'h2; s_t_keep_i = ONES;
        step();
        s_t_valid_i = 1'b0; abort_i = 1'b1;
        check_eq("t6b_pending", dig_valid_o, 1);
        step();
        abort_i = 1'b0;
        check_eq("t6b_stop", stop_o, 1);
        check_eq("t6b_flush", dig_valid_o, 0);
        check_eq("t6b_s_ready", s_t_ready_o, 0);
        dig_ready_i = 1'b1;
        wait_idle("t6b");
        step();
        check_eq("t6b_no_done", done_cnt - d0, 0);
        run_abc("t6c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
